// File: rtl/dbg_uart_pkg.sv
// Shared types and constants for the debug UART command path.
// Holds the deframer FSM states, header layout and the command bundle.
package dbg_uart_pkg;

  localparam logic [7:0] SOF_DEFAULT = 8'h01;
  localparam int WR_BIT = 7;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_CSUM,
    ST_HOLD
  } state_e;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cmd_t;

endpackage

// File: rtl/dbg_timeout_counter.sv
// Idle-cycle watchdog: counts while RUN_I, restarts on CLR_I.
// Ports: CLK_I, RST_NI, RUN_I, CLR_I in; EXPIRE_O high on the last cycle.
module dbg_timeout_counter #(
  parameter int CYCLES = 16
) (
  input  logic CLK_I,
  input  logic RST_NI,
  input  logic RUN_I,
  input  logic CLR_I,
  output logic EXPIRE_O
);

  localparam int CW = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      cnt <= '0;
    end else if (!RUN_I || CLR_I || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // A clear in the expiry cycle wins: the byte arrived in time.
  assign EXPIRE_O = RUN_I && !CLR_I && (cnt == LAST);

endmodule

// File: rtl/dbg_cmd_deframer.sv
// Assembles debug command frames from the UART byte stream (SOF, header,
// optional 4 data bytes LSB first) and holds each command on CMD_* under
// a valid/ready handshake. Pulses OVERFLOW_O, TIMEOUT_O and ERR_O.
// Ports: CLK_I, RST_NI, RX_DONE_I, DATA_I, CMD_READY_I in; CMD_*, pulses out.
// Optional: define CMD_CHECKSUM_EN for a trailing XOR checksum byte.
module dbg_cmd_deframer
  import dbg_uart_pkg::*;
#(
  parameter int         CLK_RATE       = 100 * 10**6,
  parameter int         BAUD_RATE      = 115200,
  parameter int         TIMEOUT_FRAMES = 4,
  parameter logic [7:0] SOF_BYTE       = SOF_DEFAULT
) (
  input  logic              CLK_I,
  input  logic              RST_NI,
  input  logic              RX_DONE_I,
  input  logic [7:0]        DATA_I,
  output logic              CMD_VALID_O,
  input  logic              CMD_READY_I,
  output logic              CMD_WRITE_O,
  output logic [ADDR_W-1:0] CMD_ADDR_O,
  output logic [DATA_W-1:0] CMD_DATA_O,
  output logic              OVERFLOW_O,
  output logic              TIMEOUT_O,
  output logic              ERR_O
);

  localparam int TIMEOUT_CYCLES =
    (CLK_RATE / BAUD_RATE) * 10 * TIMEOUT_FRAMES;

  state_e     state;
  cmd_t       cmd;
  logic [1:0] idx;
  logic       valid;
  logic       ovf;
  logic       tmo;
  logic       run;
  logic       expire;

`ifdef CMD_CHECKSUM_EN
  logic [7:0] csum;
  logic       err;

  assign run = (state == ST_HDR) || (state == ST_DATA) ||
               (state == ST_CSUM);
  assign ERR_O = err;
`else
  assign run = (state == ST_HDR) || (state == ST_DATA);
  assign ERR_O = 1'b0;
`endif

  dbg_timeout_counter #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_tmo (
    .CLK_I    (CLK_I),
    .RST_NI   (RST_NI),
    .RUN_I    (run),
    .CLR_I    (RX_DONE_I),
    .EXPIRE_O (expire)
  );

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      state <= ST_IDLE;
      cmd   <= '0;
      idx   <= '0;
      valid <= 1'b0;
      ovf   <= 1'b0;
      tmo   <= 1'b0;
`ifdef CMD_CHECKSUM_EN
      csum  <= '0;
      err   <= 1'b0;
`endif
    end else begin
      ovf <= 1'b0;
      tmo <= 1'b0;
`ifdef CMD_CHECKSUM_EN
      err <= 1'b0;
`endif
      unique case (state)
        ST_IDLE: begin
          if (RX_DONE_I && DATA_I == SOF_BYTE) begin
            state <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (RX_DONE_I) begin
            cmd.write <= DATA_I[WR_BIT];
            cmd.addr  <= DATA_I[ADDR_W-1:0];
            cmd.data  <= '0;
            idx       <= '0;
`ifdef CMD_CHECKSUM_EN
            csum      <= DATA_I;
`endif
            if (DATA_I[WR_BIT]) begin
              state <= ST_DATA;
            end else begin
`ifdef CMD_CHECKSUM_EN
              state <= ST_CSUM;
`else
              state <= ST_HOLD;
              valid <= 1'b1;
`endif
            end
          end else if (expire) begin
            tmo   <= 1'b1;
            cmd   <= '0;
            state <= ST_IDLE;
          end
        end
        ST_DATA: begin
          if (RX_DONE_I) begin
            cmd.data[{idx, 3'b000} +: 8] <= DATA_I;
            idx <= idx + 2'd1;
`ifdef CMD_CHECKSUM_EN
            csum <= csum ^ DATA_I;
`endif
            if (idx == 2'd3) begin
`ifdef CMD_CHECKSUM_EN
              state <= ST_CSUM;
`else
              state <= ST_HOLD;
              valid <= 1'b1;
`endif
            end
          end else if (expire) begin
            tmo   <= 1'b1;
            cmd   <= '0;
            idx   <= '0;
            state <= ST_IDLE;
          end
        end
`ifdef CMD_CHECKSUM_EN
        ST_CSUM: begin
          if (RX_DONE_I) begin
            if (DATA_I == csum) begin
              state <= ST_HOLD;
              valid <= 1'b1;
            end else begin
              err   <= 1'b1;
              cmd   <= '0;
              state <= ST_IDLE;
            end
          end else if (expire) begin
            tmo   <= 1'b1;
            cmd   <= '0;
            state <= ST_IDLE;
          end
        end
`endif
        ST_HOLD: begin
          // Any byte here is lost, even if the handshake completes now.
          if (RX_DONE_I) begin
            ovf <= 1'b1;
          end
          if (CMD_READY_I) begin
            valid <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign CMD_VALID_O = valid;
  assign CMD_WRITE_O = cmd.write;
  assign CMD_ADDR_O  = cmd.addr;
  assign CMD_DATA_O  = cmd.data;
  assign OVERFLOW_O  = ovf;
  assign TIMEOUT_O   = tmo;

endmodule

// File: tb/tb_dbg_cmd_deframer.sv
// Directed scoreboard bench for dbg_cmd_deframer.
// Honours CMD_CHECKSUM_EN by appending the XOR checksum byte.
module tb_dbg_cmd_deframer;
  import dbg_uart_pkg::*;

  localparam int CLK_RATE = 1_843_200;
  localparam int BAUD     = 115200;
  localparam int TFR      = 4;
  localparam int TC       = (CLK_RATE / BAUD) * 10 * TFR;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b0;
  logic [7:0]  din = 8'h00;
  logic        ready = 1'b0;
  logic        valid;
  logic        write;
  logic [6:0]  addr;
  logic [31:0] data;
  logic        ovf;
  logic        tmo;
  logic        err;

  always #5 clk = ~clk;

  dbg_cmd_deframer #(
    .CLK_RATE       (CLK_RATE),
    .BAUD_RATE      (BAUD),
    .TIMEOUT_FRAMES (TFR),
    .SOF_BYTE       (8'h01)
  ) dut (
    .CLK_I       (clk),
    .RST_NI      (rst_n),
    .RX_DONE_I   (rx),
    .DATA_I      (din),
    .CMD_VALID_O (valid),
    .CMD_READY_I (ready),
    .CMD_WRITE_O (write),
    .CMD_ADDR_O  (addr),
    .CMD_DATA_O  (data),
    .OVERFLOW_O  (ovf),
    .TIMEOUT_O   (tmo),
    .ERR_O       (err)
  );

  int   tests = 0;
  int   fails = 0;
  int   n_tmo = 0;
  int   n_ovf = 0;
  int   n_err = 0;
  int   n_valid = 0;
  cmd_t exp_q[$];
  cmd_t e_mon;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Sample mid-low-phase: inputs settled, next edge not yet reached.
  always @(negedge clk) begin
    #3;
    if (tmo) n_tmo++;
    if (ovf) n_ovf++;
    if (err) n_err++;
    if (valid) n_valid++;
    if (valid && ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_cmd", 64'd1, 64'd0);
      end else begin
        e_mon = exp_q.pop_front();
        chk("sb_cmd", {24'h0, write, addr, data}, {24'h0, e_mon});
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx  = 1'b1;
    din = b;
    @(negedge clk);
    rx  = 1'b0;
  endtask

  task automatic send_frame(input logic wr, input logic [6:0] a,
                            input logic [31:0] d);
    cmd_t e;
`ifdef CMD_CHECKSUM_EN
    logic [7:0] cs;
    cs = {wr, a};
`endif
    e.write = wr;
    e.addr  = a;
    e.data  = wr ? d : 32'h0;
    exp_q.push_back(e);
    send_byte(8'h01);
    send_byte({wr, a});
    if (wr) begin
      for (int i = 0; i < 4; i++) begin
        send_byte(d[8*i +: 8]);
`ifdef CMD_CHECKSUM_EN
        cs = cs ^ d[8*i +: 8];
`endif
      end
    end
`ifdef CMD_CHECKSUM_EN
    send_byte(cs);
`endif
  endtask

  initial begin
    int   t0;
    int   v0;
    int   o0;
    int   e0;
    logic ok;

    idle(2);
    chk("reset_outs", {24'h0, valid, write, addr, data, ovf, tmo, err},
        64'h0);
    rst_n = 1'b1;
    idle(2);

    // Read frame, ready high: one-cycle valid.
    ready = 1'b1;
    send_frame(1'b0, 7'h05, 32'h0);
    chk("t1_valid", {63'h0, valid}, 64'd1);
    chk("t1_fields", {24'h0, write, addr, data}, {24'h0, 1'b0, 7'h05, 32'h0});
    idle(1);
    chk("t1_drop", {63'h0, valid}, 64'd0);

    // Write frame held while ready low.
    ready = 1'b0;
    send_frame(1'b1, 7'h05, 32'hDEADBEEF);
    chk("t2_valid", {63'h0, valid}, 64'd1);
    chk("t2_fields", {24'h0, write, addr, data},
        {24'h0, 1'b1, 7'h05, 32'hDEADBEEF});
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if ({valid, write, addr, data} !== {1'b1, 1'b1, 7'h05, 32'hDEADBEEF})
        ok = 1'b0;
    end
    chk("t2_stable", {63'h0, ok}, 64'd1);
    ready = 1'b1;
    idle(1);
    chk("t2_drop", {63'h0, valid}, 64'd0);

    // Junk before SOF is ignored.
    send_byte(8'h7F);
    send_byte(8'h33);
    chk("t3_ignored", {63'h0, valid}, 64'd0);
    send_frame(1'b0, 7'h02, 32'h0);
    chk("t3_valid", {63'h0, valid}, 64'd1);
    chk("t3_fields", {24'h0, write, addr, data}, {24'h0, 1'b0, 7'h02, 32'h0});
    idle(2);

    // Partial frame then silence: single timeout, no command.
    t0 = n_tmo;
    v0 = n_valid;
    send_byte(8'h01);
    send_byte(8'h81);
    send_byte(8'h11);
    idle(TC - 5);
    chk("t4_not_early", 64'(n_tmo - t0), 64'd0);
    idle(15);
    chk("t4_tmo_once", 64'(n_tmo - t0), 64'd1);
    chk("t4_no_valid", 64'(n_valid - v0), 64'd0);
    send_frame(1'b0, 7'h03, 32'h0);
    chk("t4_after", {24'h0, valid, addr, data}, {24'h0, 1'b1, 7'h03, 32'h0});
    idle(2);

    // Overflow while holding, then overflow on the handshake cycle.
    ready = 1'b0;
    o0 = n_ovf;
    send_frame(1'b1, 7'h2A, 32'h12345678);
    send_byte(8'h55);
    idle(1);
    chk("t5_ovf", 64'(n_ovf - o0), 64'd1);
    chk("t5_held", {24'h0, valid, write, addr, data},
        {24'h0, 1'b1, 1'b1, 7'h2A, 32'h12345678});
    @(negedge clk);
    ready = 1'b1;
    rx    = 1'b1;
    din   = 8'h66;
    @(negedge clk);
    rx    = 1'b0;
    chk("t5_hs_drop", {63'h0, valid}, 64'd0);
    idle(1);
    chk("t5_ovf_hs", 64'(n_ovf - o0), 64'd2);

    // Asynchronous reset mid-frame.
    send_byte(8'h01);
    send_byte(8'h85);
    send_byte(8'hEF);
    chk("t5_pre_rst", {56'h0, write, addr}, {56'h0, 1'b1, 7'h05});
    #2 rst_n = 1'b0;
    #1 chk("t5_rst_outs", {24'h0, valid, write, addr, data, ovf, tmo, err},
           64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    send_frame(1'b0, 7'h07, 32'h0);
    chk("t5_after_rst", {24'h0, valid, write, addr, data},
        {24'h0, 1'b1, 1'b0, 7'h07, 32'h0});
    idle(2);

`ifdef CMD_CHECKSUM_EN
    e0 = n_err;
    exp_q.push_back('{write: 1'b0, addr: 7'h05, data: 32'h0});
    send_byte(8'h01);
    send_byte(8'h05);
    send_byte(8'h05);
    chk("t6_good", {63'h0, valid}, 64'd1);
    idle(2);
    v0 = n_valid;
    send_byte(8'h01);
    send_byte(8'h05);
    send_byte(8'h06);
    idle(2);
    chk("t6_err", 64'(n_err - e0), 64'd1);
    chk("t6_no_valid", 64'(n_valid - v0), 64'd0);
`else
    e0 = 0;
    chk("err_tied", 64'(n_err - e0), 64'd0);
`endif

    idle(2);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
